// File: rtl/fic_arith_pkg.sv
// rtl/fic_arith_pkg.sv - shared arithmetic constants and divider state encoding
//
// Purpose: definitions shared by the sign-extension stage and the sequential
//          signed divider.
// Contents:
//   FIC_OPERAND_W  default operand width (dividend is twice this width)
//   ST_*           3-bit divider state encodings
//   div_state_e    enumerated divider state type built on ST_*
package fic_arith_pkg;

  localparam int FIC_OPERAND_W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    PREP = ST_PREP,
    RUN  = ST_RUN,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } div_state_e;

endpackage

// File: rtl/seq_signed_divider_if.sv
// rtl/seq_signed_divider_if.sv - operand/result handshake bundle for the divider
//
// Purpose: groups the operand and result valid/ready channels of the divider.
// Signals:
//   in_valid, in_ready      operand handshake
//   dividend [2W-1:0]       signed, sign-extended dividend
//   divisor  [W-1:0]        signed divisor
//   out_valid, out_ready    result handshake
//   quotient, remainder     signed W-bit results
//   div_zero, overflow      result flags, valid with out_valid
//   busy                    divider not in IDLE
// Modports: master = operand producer / result consumer, slave = divider.
interface seq_signed_divider_if
  import fic_arith_pkg::*;
#(
  parameter int W = FIC_OPERAND_W
);

  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   dividend;
  logic [W-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     quotient;
  logic [W-1:0]     remainder;
  logic             div_zero;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, overflow, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, overflow, busy
  );

endinterface

// File: rtl/seq_signed_divider_div_step.sv
// rtl/seq_signed_divider_div_step.sv - one restoring shift-subtract iteration
//
// Purpose: combinational single step of unsigned restoring division.
// Ports:
//   prem_in  [W:0]    partial remainder before this step
//   din               next dividend magnitude bit (MSB first)
//   dvs_mag  [W-1:0]  divisor magnitude (non-zero)
//   prem_out [W:0]    partial remainder after this step
//   q_bit             quotient bit produced by this step
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   prem_in,
  input  logic         din,
  input  logic [W-1:0] dvs_mag,
  output logic [W:0]   prem_out,
  output logic         q_bit
);

  // One extra bit on the shifted value keeps the compare exact even if the
  // incoming remainder were ever at its full W+1-bit range.
  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  always_comb begin
    shifted  = {prem_in, din};
    diff     = shifted - {2'b00, dvs_mag};
    q_bit    = (shifted >= {2'b00, dvs_mag});
    prem_out = q_bit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - multi-cycle truncating signed divider
//
// Purpose: divides a 2W-bit signed dividend by a W-bit signed divisor using
//          restoring division on magnitudes followed by a sign fix-up.
//          Quotient rounds toward zero; remainder takes the dividend's sign.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seq_signed_divider_if.slave: operand/result handshakes, results,
//          div_zero / overflow flags and busy
// Timing: accept edge = 0; result valid after edge 2W+2 (edge 2 for a zero
//          divisor). One operation at a time; operands offered while busy
//          are dropped.
module seq_signed_divider
  import fic_arith_pkg::*;
#(
  parameter int W = FIC_OPERAND_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_signed_divider_if.slave    bus
);

  localparam int QW = 2 * W;
  localparam int CW = $clog2(QW);

  // Largest positive and negative quotient magnitudes representable in W bits.
  localparam logic [QW-1:0] POS_LIM = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [QW-1:0] NEG_LIM = POS_LIM + QW'(1);

  div_state_e state_q, state_d;

  logic [QW-1:0] dvd_q;
  logic [W-1:0]  dvs_q;
  logic          sign_dvd_q;
  logic          sign_dvs_q;
  logic          zero_q;
  // Holds |dividend| at the start of RUN; quotient bits shift in from the
  // bottom as dividend bits shift out of the top, so it ends as |quotient|.
  logic [QW-1:0] acc_q;
  logic [W-1:0]  dvs_mag_q;
  logic [W:0]    prem_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic          dz_q;
  logic          ov_q;

  logic [W:0]    prem_next;
  logic          q_bit;

  logic [QW-1:0] dvd_mag;
  logic [W-1:0]  dvs_mag;
  logic          q_neg;
  logic [W-1:0]  q_lo;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  quo_fix;
  logic [W-1:0]  rem_fix;
  logic          ov_fix;
  logic          unused_prem_top;

  div_step #(.W(W)) u_step (
    .prem_in  (prem_q),
    .din      (acc_q[QW-1]),
    .dvs_mag  (dvs_mag_q),
    .prem_out (prem_next),
    .q_bit    (q_bit)
  );

  // Two's-complement negation also maps the most negative value onto its
  // unsigned magnitude (e.g. 16'h8000 -> 32768).
  always_comb begin
    dvd_mag = sign_dvd_q ? (~dvd_q + QW'(1)) : dvd_q;
    dvs_mag = sign_dvs_q ? (~dvs_q + W'(1))  : dvs_q;
  end

  // The remainder magnitude is below |divisor| <= 2^(W-1), so its top bit
  // is always clear by the time FIX reads it.
  assign unused_prem_top = prem_q[W];

  always_comb begin
    q_neg   = sign_dvd_q ^ sign_dvs_q;
    q_lo    = acc_q[W-1:0];
    r_lo    = prem_q[W-1:0];
    quo_fix = q_neg ? (~q_lo + W'(1)) : q_lo;
    rem_fix = sign_dvd_q ? (~r_lo + W'(1)) : r_lo;
    ov_fix  = q_neg ? (acc_q > NEG_LIM) : (acc_q > POS_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A zero divisor skips RUN but still passes through FIX so that every
  // result is loaded into the output registers from the same state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = PREP;
      PREP: state_d = (dvs_q == '0) ? FIX : RUN;
      RUN:  if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q      <= '0;
      dvs_q      <= '0;
      sign_dvd_q <= 1'b0;
      sign_dvs_q <= 1'b0;
      zero_q     <= 1'b0;
      acc_q      <= '0;
      dvs_mag_q  <= '0;
      prem_q     <= '0;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dz_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            dvd_q      <= bus.dividend;
            dvs_q      <= bus.divisor;
            sign_dvd_q <= bus.dividend[QW-1];
            sign_dvs_q <= bus.divisor[W-1];
          end
        end
        PREP: begin
          zero_q    <= (dvs_q == '0);
          acc_q     <= dvd_mag;
          dvs_mag_q <= dvs_mag;
          prem_q    <= '0;
          cnt_q     <= CW'(QW - 1);
        end
        RUN: begin
          acc_q  <= {acc_q[QW-2:0], q_bit};
          prem_q <= prem_next;
          cnt_q  <= cnt_q - CW'(1);
        end
        FIX: begin
          if (zero_q) begin
            quo_q <= '0;
            rem_q <= dvd_q[W-1:0];
            dz_q  <= 1'b1;
            ov_q  <= 1'b0;
          end else begin
            quo_q <= quo_fix;
            rem_q <= rem_fix;
            dz_q  <= 1'b0;
            ov_q  <= ov_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.overflow  = ov_q;

endmodule
